// File: rtl/lfsr_note_bank.sv
// Three independent Fibonacci LFSR channels with per-channel enable and a
// registered wrap pulse. Optional zero-state recovery: LFSR_LOCKUP_RECOVER_EN.
module lfsr_note_bank #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED1 = 8'h01,
    parameter logic [WIDTH-1:0] SEED2 = 8'h5A,
    parameter logic [WIDTH-1:0] SEED3 = 8'hC3,
    parameter logic [WIDTH-1:0] TAPS1 = 8'hB8,
    parameter logic [WIDTH-1:0] TAPS2 = 8'h8E,
    parameter logic [WIDTH-1:0] TAPS3 = 8'hFA
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       en,
    output logic [WIDTH-1:0] lfsr1,
    output logic [WIDTH-1:0] lfsr2,
    output logic [WIDTH-1:0] lfsr3,
    output logic [2:0]       wrap
);

    // Per-channel constants packed so the generate loop can slice them by index.
    localparam logic [3*WIDTH-1:0] SEED_ALL = {SEED3, SEED2, SEED1};
    localparam logic [3*WIDTH-1:0] TAPS_ALL = {TAPS3, TAPS2, TAPS1};

    logic [3*WIDTH-1:0] state_all;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : ch_g
            localparam logic [WIDTH-1:0] SEED = SEED_ALL[gi*WIDTH +: WIDTH];
            localparam logic [WIDTH-1:0] TAPS = TAPS_ALL[gi*WIDTH +: WIDTH];

            logic [WIDTH-1:0] state_reg;
            logic [WIDTH-1:0] state_next;
            logic             wrap_reg;
            logic             lockup;

            always_comb begin
                state_next = {state_reg[WIDTH-2:0], ^(state_reg & TAPS)};
            end

`ifdef LFSR_LOCKUP_RECOVER_EN
            assign lockup = (state_reg == '0);
`else
            assign lockup = 1'b0;
`endif

            // A lockup reload is not a sequence wrap, so it never pulses wrap.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg <= SEED;
                    wrap_reg  <= 1'b0;
                end else if (lockup) begin
                    state_reg <= SEED;
                    wrap_reg  <= 1'b0;
                end else if (en[gi]) begin
                    state_reg <= state_next;
                    wrap_reg  <= (state_next == SEED);
                end else begin
                    wrap_reg  <= 1'b0;
                end
            end

            assign state_all[gi*WIDTH +: WIDTH] = state_reg;
            assign wrap[gi]                     = wrap_reg;
        end
    endgenerate

    assign lfsr1 = state_all[0*WIDTH +: WIDTH];
    assign lfsr2 = state_all[1*WIDTH +: WIDTH];
    assign lfsr3 = state_all[2*WIDTH +: WIDTH];

endmodule

// File: tb/tb_lfsr_note_bank.sv
// Self-checking bench for lfsr_note_bank: each channel is modelled as a
// precomputed period table indexed by a step counter modulo 255.
module tb_lfsr_note_bank;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] en = 3'b000;
    logic [7:0] lfsr1, lfsr2, lfsr3;
    logic [2:0] wrap;

    int tests_run = 0;
    int fails = 0;

    logic [7:0] seeds [3];
    logic [7:0] taps  [3];
    logic [7:0] seq   [3][255];
    int         cnt   [3];
    logic [2:0] exp_wrap;

    always #5 clk = ~clk;

    lfsr_note_bank dut (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .lfsr1  (lfsr1),
        .lfsr2  (lfsr2),
        .lfsr3  (lfsr3),
        .wrap   (wrap)
    );

    // Reference: the whole period of each channel, built from the tap rule.
    task automatic build_model();
        seeds[0] = 8'h01; seeds[1] = 8'h5A; seeds[2] = 8'hC3;
        taps[0]  = 8'hB8; taps[1]  = 8'h8E; taps[2]  = 8'hFA;
        for (int k = 0; k < 3; k++) begin
            logic [7:0] s;
            logic       fb;
            s = seeds[k];
            for (int i = 0; i < 255; i++) begin
                seq[k][i] = s;
                fb = ($countones(s & taps[k]) % 2) == 1;
                s  = {s[6:0], fb};
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) cnt[k] = 0;
        exp_wrap = 3'b000;
    endtask

    task automatic model_step(input logic [2:0] e);
        for (int k = 0; k < 3; k++) begin
            if (e[k]) begin
                cnt[k]      = (cnt[k] + 1) % 255;
                exp_wrap[k] = (cnt[k] == 0);
            end else begin
                exp_wrap[k] = 1'b0;
            end
        end
    endtask

    function automatic logic [26:0] exp_vec();
        return {seq[0][cnt[0]], seq[1][cnt[1]], seq[2][cnt[2]], exp_wrap};
    endfunction

    // Apply one clock with the given enables; leaves time at posedge+1.
    task automatic drive(input logic [2:0] e);
        en = e;
        @(posedge clk);
        #1;
        model_step(e);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        en = 3'b000;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({lfsr1, lfsr2, lfsr3, wrap} !== {8'h01, 8'h5A, 8'hC3, 3'b000}) begin
            fails++;
            $display("FAIL reset: got %h required %h", {lfsr1, lfsr2, lfsr3, wrap},
                     {8'h01, 8'h5A, 8'hC3, 3'b000});
        end
        $display("[TB] reset lfsr=%h/%h/%h wrap=%b", lfsr1, lfsr2, lfsr3, wrap);
        en = 3'b000;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_ch1_step();
        logic [7:0] table1 [5];
        table1 = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(3'b001);
            tests_run++;
            if ({lfsr1, lfsr2, lfsr3, wrap} !== {table1[i], 8'h5A, 8'hC3, 3'b000}) begin
                fails++;
                $display("FAIL ch1_step[%0d]: got %h required %h", i,
                         {lfsr1, lfsr2, lfsr3, wrap}, {table1[i], 8'h5A, 8'hC3, 3'b000});
            end
            $display("[TB] ch1_step %0d lfsr1=%h", i, lfsr1);
        end
    endtask

    task automatic test_hold_resume();
        apply_reset();
        drive(3'b001);
        drive(3'b001);
        for (int i = 0; i < 10; i++) begin
            drive(3'b000);
            tests_run++;
            if (lfsr1 !== 8'h04 || {lfsr1, lfsr2, lfsr3, wrap} !== exp_vec()) begin
                fails++;
                $display("FAIL hold[%0d]: got %h required %h", i,
                         {lfsr1, lfsr2, lfsr3, wrap}, exp_vec());
            end
            $display("[TB] hold %0d lfsr1=%h", i, lfsr1);
        end
        drive(3'b001);
        tests_run++;
        if (lfsr1 !== 8'h08 || {lfsr1, lfsr2, lfsr3, wrap} !== exp_vec()) begin
            fails++;
            $display("FAIL resume: got %h required %h", {lfsr1, lfsr2, lfsr3, wrap}, exp_vec());
        end
        $display("[TB] resume lfsr1=%h", lfsr1);
    endtask

    task automatic test_period();
        apply_reset();
        for (int i = 1; i <= 256; i++) begin
            drive(3'b111);
            tests_run++;
            if ({lfsr1, lfsr2, lfsr3, wrap} !== exp_vec()) begin
                fails++;
                $display("FAIL period[%0d]: got %h required %h", i,
                         {lfsr1, lfsr2, lfsr3, wrap}, exp_vec());
            end
            if (lfsr1 == 8'h00 || lfsr2 == 8'h00 || lfsr3 == 8'h00) begin
                fails++;
                $display("FAIL period_zero[%0d]: got %h/%h/%h required nonzero", i,
                         lfsr1, lfsr2, lfsr3);
            end
            if (i < 255 && (lfsr1 == 8'h01 || lfsr2 == 8'h5A || lfsr3 == 8'hC3 || wrap != 3'b000)) begin
                fails++;
                $display("FAIL period_early[%0d]: got %h/%h/%h wrap=%b required no seed", i,
                         lfsr1, lfsr2, lfsr3, wrap);
            end
            if (i == 255) begin
                tests_run++;
                if ({lfsr1, lfsr2, lfsr3, wrap} !== {8'h01, 8'h5A, 8'hC3, 3'b111}) begin
                    fails++;
                    $display("FAIL period_wrap: got %h required %h",
                             {lfsr1, lfsr2, lfsr3, wrap}, {8'h01, 8'h5A, 8'hC3, 3'b111});
                end
            end
            $display("[TB] period %0d lfsr=%h/%h/%h wrap=%b", i, lfsr1, lfsr2, lfsr3, wrap);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            logic [2:0] e;
            e = 3'($urandom_range(0, 7));
            drive(e);
            tests_run++;
            if ({lfsr1, lfsr2, lfsr3, wrap} !== exp_vec()) begin
                fails++;
                $display("FAIL random[%0d] en=%b: got %h required %h", i, e,
                         {lfsr1, lfsr2, lfsr3, wrap}, exp_vec());
            end
            $display("[TB] random %0d en=%b lfsr=%h/%h/%h wrap=%b", i, e, lfsr1, lfsr2, lfsr3, wrap);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 37; i++) drive(3'b111);
        tests_run++;
        if ({lfsr1, lfsr2, lfsr3, wrap} !== exp_vec()) begin
            fails++;
            $display("FAIL async_pre: got %h required %h", {lfsr1, lfsr2, lfsr3, wrap}, exp_vec());
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({lfsr1, lfsr2, lfsr3, wrap} !== {8'h01, 8'h5A, 8'hC3, 3'b000}) begin
            fails++;
            $display("FAIL async_reset: got %h required %h", {lfsr1, lfsr2, lfsr3, wrap},
                     {8'h01, 8'h5A, 8'hC3, 3'b000});
        end
        $display("[TB] async_reset lfsr=%h/%h/%h wrap=%b", lfsr1, lfsr2, lfsr3, wrap);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        drive(3'b111);
        tests_run++;
        if ({lfsr1, lfsr2, lfsr3, wrap} !== exp_vec()) begin
            fails++;
            $display("FAIL async_release: got %h required %h", {lfsr1, lfsr2, lfsr3, wrap}, exp_vec());
        end
        $display("[TB] async_release lfsr=%h/%h/%h wrap=%b", lfsr1, lfsr2, lfsr3, wrap);
    endtask

    initial begin
        build_model();
        model_reset();
        test_reset();
        test_ch1_step();
        test_hold_resume();
        test_period();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
